// File: rtl/z80_wb_bus_master.sv
// rtl/z80_wb_bus_master.sv - Z80 memory bus to pipelined Wishbone initiator
// Syncs the async Z80 strobes, issues one Wishbone transfer per Z80 cycle and holds WAIT until ack or timeout.
module z80_wb_bus_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = 7,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA = 8'hFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_z80_mreq_n,
  input  logic                  i_z80_rd_n,
  input  logic                  i_z80_wr_n,
  input  logic [ADDR_WIDTH-1:0] i_z80_addr,
  input  logic [DATA_WIDTH-1:0] i_z80_data,
  output logic [DATA_WIDTH-1:0] o_z80_data,
  output logic                  o_z80_data_oe,
  output logic                  o_z80_wait_n,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_bus_error
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]            mreq_sync, rd_sync, wr_sync;
  logic [ADDR_WIDTH-1:0] addr_p1, addr_p2;
  logic [DATA_WIDTH-1:0] data_p1, data_p2;
  logic [1:0]            fill;
  state_t                state;
  logic                  armed;
  logic [TIMEOUT_WIDTH-1:0] tcount;

  logic mreq_s, rd_s, wr_s, fill_done, request, finish_ok, timed_out;

  assign mreq_s    = mreq_sync[1];
  assign rd_s      = rd_sync[1];
  assign wr_s      = wr_sync[1];
  assign fill_done = (fill == 2'd2);
  assign request   = !mreq_s && (rd_s != wr_s);
  assign timed_out = (tcount == TIMEOUT_LAST);
  assign finish_ok = i_wb_ack && ((state == ACK) || (state == REQ && !i_wb_stall));

  // The fill counter keeps the reset value of the synchronisers from looking like a real MREQ_n high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mreq_sync <= 2'b11;
      rd_sync   <= 2'b11;
      wr_sync   <= 2'b11;
      addr_p1   <= '0;
      addr_p2   <= '0;
      data_p1   <= '0;
      data_p2   <= '0;
      fill      <= 2'd0;
    end else begin
      mreq_sync <= {mreq_sync[0], i_z80_mreq_n};
      rd_sync   <= {rd_sync[0], i_z80_rd_n};
      wr_sync   <= {wr_sync[0], i_z80_wr_n};
      addr_p1   <= i_z80_addr;
      addr_p2   <= addr_p1;
      data_p1   <= i_z80_data;
      data_p2   <= data_p1;
      if (!fill_done) fill <= fill + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      armed         <= 1'b0;
      tcount        <= '0;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_addr     <= '0;
      o_wb_data     <= '0;
      o_z80_data    <= '0;
      o_z80_data_oe <= 1'b0;
      o_z80_wait_n  <= 1'b1;
      o_bus_error   <= 1'b0;
    end else begin
      o_bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (mreq_s && fill_done) armed <= 1'b1;
          if (request && armed) begin
            o_wb_we      <= !wr_s;
            o_wb_addr    <= addr_p2;
            o_wb_data    <= data_p2;
            o_wb_cyc     <= 1'b1;
            o_wb_stb     <= 1'b1;
            o_z80_wait_n <= 1'b0;
            armed        <= 1'b0;
            tcount       <= '0;
            state        <= REQ;
          end
        end
        REQ, ACK: begin
          if (state == REQ && !i_wb_stall) begin
            o_wb_stb <= 1'b0;
            state    <= ACK;
          end
          // A late ack on the timeout cycle still counts as a normal completion.
          if (finish_ok) begin
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_z80_wait_n <= 1'b1;
            if (!o_wb_we) begin
              o_z80_data    <= i_wb_data;
              o_z80_data_oe <= 1'b1;
            end
            state <= HOLD;
          end else if (timed_out) begin
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_z80_wait_n <= 1'b1;
            o_bus_error  <= 1'b1;
            if (!o_wb_we) begin
              o_z80_data    <= ERROR_DATA;
              o_z80_data_oe <= 1'b1;
            end
            state <= HOLD;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        HOLD: begin
          if (mreq_s) begin
            o_z80_data_oe <= 1'b0;
            armed         <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_wb_bus_master.sv
// tb/tb_z80_wb_bus_master.sv - scoreboard bench for z80_wb_bus_master
// Z80 cycles push expected Wishbone/read-data entries; the stb monitor and Z80 task pop and compare.
module tb_z80_wb_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, rd_n, wr_n;
  logic [15:0] z80_addr;
  logic [7:0]  z80_wdata;
  logic [7:0]  o_z80_data;
  logic        o_z80_data_oe, o_z80_wait_n;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [15:0] o_wb_addr;
  logic [7:0]  o_wb_data;
  logic        i_wb_ack, i_wb_stall;
  logic [7:0]  i_wb_data;
  logic        o_bus_error;

  always #5 clk = ~clk;

  z80_wb_bus_master dut (
    .i_clk(clk), .i_reset(reset),
    .i_z80_mreq_n(mreq_n), .i_z80_rd_n(rd_n), .i_z80_wr_n(wr_n),
    .i_z80_addr(z80_addr), .i_z80_data(z80_wdata),
    .o_z80_data(o_z80_data), .o_z80_data_oe(o_z80_data_oe), .o_z80_wait_n(o_z80_wait_n),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
    .o_bus_error(o_bus_error)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } wb_exp_t;

  wb_exp_t    wb_q[$];
  logic [7:0] rd_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int stb_accepts = 0, stb_cycles = 0, err_cycles = 0, oe_cycles = 0;

  // slave configuration: ack_mode 0 = never, 1 = cycle after accept, 2 = when cyc_cnt hits ack_at
  int   stall_cfg = 0, ack_mode = 1, ack_at = 0;
  logic stray_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int  stall_left, cyc_cnt;
    bit  will_accept;
    i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 8'h00;
    stall_left = 0; cyc_cnt = 0; will_accept = 0;
    forever begin
      @(posedge clk); #1;
      i_wb_ack = 1'b0;
      if (reset || !o_wb_cyc) begin
        cyc_cnt = 0; stall_left = stall_cfg; will_accept = 0; i_wb_stall = 1'b0;
      end else begin
        cyc_cnt++;
        if (will_accept && ack_mode == 1) i_wb_ack = 1'b1;
        if (ack_mode == 2 && cyc_cnt == ack_at) i_wb_ack = 1'b1;
        will_accept = 0;
        if (o_wb_stb) begin
          if (stall_left > 0) begin
            i_wb_stall = 1'b1; stall_left--;
          end else begin
            i_wb_stall = 1'b0; will_accept = 1;
          end
        end else begin
          i_wb_stall = 1'b0;
        end
      end
      if (stray_ack) i_wb_ack = 1'b1;
    end
  end

  always @(negedge clk) begin
    wb_exp_t e;
    if (o_wb_cyc && o_wb_stb) stb_cycles++;
    if (o_bus_error) err_cycles++;
    if (o_z80_data_oe) oe_cycles++;
    if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
      stb_accepts++;
      if (wb_q.size() == 0) check("unexpected_stb", 1, 0);
      else begin
        e = wb_q.pop_front();
        check("wb_we", o_wb_we, e.we);
        check("wb_addr", o_wb_addr, e.addr);
        if (e.we) check("wb_data", o_wb_data, e.data);
      end
    end
  end

  task automatic z80_access(input bit is_rd, input logic [15:0] a, input logic [7:0] d, output int lat);
    bit seen_low;
    logic [7:0] exp;
    @(negedge clk);
    z80_addr = a; z80_wdata = d;
    mreq_n = 1'b0; rd_n = !is_rd; wr_n = is_rd;
    lat = 0; seen_low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (!o_z80_wait_n) seen_low = 1;
      else if (seen_low) break;
    end
    check("wait_cycle_done", {31'd0, seen_low & o_z80_wait_n}, 1);
    if (is_rd) begin
      exp = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hxx;
      check("rd_oe", o_z80_data_oe, 1);
      check("rd_data", o_z80_data, exp);
      repeat (2) @(negedge clk);
      check("rd_oe_hold", o_z80_data_oe, 1);
    end else begin
      check("wr_oe", o_z80_data_oe, 0);
      repeat (2) @(negedge clk);
    end
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(negedge clk);
    check("oe_release", o_z80_data_oe, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n0, e0;
    bit ok;
    reset = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    z80_addr = 16'h0; z80_wdata = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_wait_n", o_z80_wait_n, 1);
    check("rst_oe", o_z80_data_oe, 0);
    check("rst_err", o_bus_error, 0);
    check("rst_wb_addr", o_wb_addr, 0);
    check("rst_z80_data", o_z80_data, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // zero-stall read
    stall_cfg = 0; ack_mode = 1; i_wb_data = 8'h3C;
    wb_q.push_back('{1'b0, 16'h0123, 8'h00});
    rd_q.push_back(8'h3C);
    z80_access(1, 16'h0123, 8'h00, lat);
    check("rd_latency", lat, 5);

    // write with 3 stall cycles
    stall_cfg = 3; n0 = stb_accepts; stb_cycles = 0; oe_cycles = 0;
    wb_q.push_back('{1'b1, 16'h8000, 8'hA5});
    z80_access(0, 16'h8000, 8'hA5, lat);
    check("wr_latency", lat, 8);
    check("wr_stb_cycles", stb_cycles, 4);
    check("wr_accepts", stb_accepts - n0, 1);
    check("wr_oe_never", oe_cycles, 0);

    // no ack: timeout abort
    stall_cfg = 0; ack_mode = 0; err_cycles = 0; i_wb_data = 8'h12;
    wb_q.push_back('{1'b0, 16'h2000, 8'h00});
    rd_q.push_back(8'hFF);
    z80_access(1, 16'h2000, 8'h00, lat);
    check("to_latency", lat, 67);
    check("to_err_pulse", err_cycles, 1);
    check("to_cyc", o_wb_cyc, 0);

    // ack coincides with the timeout cycle
    ack_mode = 2; ack_at = 64; err_cycles = 0; i_wb_data = 8'h5A;
    wb_q.push_back('{1'b0, 16'h2001, 8'h00});
    rd_q.push_back(8'h5A);
    z80_access(1, 16'h2001, 8'h00, lat);
    check("tie_latency", lat, 67);
    check("tie_no_err", err_cycles, 0);

    // reset while waiting for ack, MREQ_n held low
    ack_mode = 0;
    wb_q.push_back('{1'b0, 16'h4444, 8'h00});
    @(negedge clk);
    z80_addr = 16'h4444; mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
    n0 = stb_accepts; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stb_accepts != n0) begin ok = 1; break; end
    end
    check("rst_mid_issue", {31'd0, ok}, 1);
    @(negedge clk);
    check("rst_mid_in_ack", o_wb_cyc, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_cyc", o_wb_cyc, 0);
    check("rst_mid_wait_n", o_z80_wait_n, 1);
    n0 = stb_accepts;
    repeat (10) @(negedge clk);
    check("rst_mid_no_stb", stb_accepts, n0);
    check("rst_mid_wait_hold", o_z80_wait_n, 1);
    mreq_n = 1'b1; rd_n = 1'b1;
    repeat (4) @(negedge clk);

    // rd_n and wr_n both low, then a stray ack while idle
    n0 = stb_accepts; e0 = err_cycles;
    @(negedge clk);
    mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("both_low_wait_n", o_z80_wait_n, 1);
    end
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_no_stb", stb_accepts, n0);
    check("stray_cyc", o_wb_cyc, 0);
    check("stray_wait_n", o_z80_wait_n, 1);
    check("stray_no_err", err_cycles, e0);

    // normal read still works at the top address
    ack_mode = 1; i_wb_data = 8'h77;
    wb_q.push_back('{1'b0, 16'hFFFF, 8'h00});
    rd_q.push_back(8'h77);
    z80_access(1, 16'hFFFF, 8'h00, lat);
    check("final_latency", lat, 5);
    check("wb_q_empty", wb_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_wb_bus_master.md
Name: z80_wb_bus_master

Overview:
Wishbone initiator that turns the asynchronous Z80 memory bus (MREQ_n/RD_n/WR_n, address, data) into single pipelined Wishbone transactions towards the memory adapter. It is the CPU-side counterpart of the memory adapter's responder port. It synchronises the Z80 strobes into i_clk and holds the Z80 in WAIT until the Wishbone ack returns. It then drives read data back to the Z80 until the cycle ends. A timeout protects the Z80 from a hung bus.

Parameters:
ADDR_WIDTH, 16, Z80/Wishbone address width
DATA_WIDTH, 8, data width
TIMEOUT_CYCLES, 64, i_clk cycles from strobe issue to forced abort
TIMEOUT_WIDTH, 7, counter width; must hold TIMEOUT_CYCLES
ERROR_DATA, 8'hFF, value returned to the Z80 on a timed-out read

Ports:
i_clk  in  1  system clock, only clock
i_reset  in  1  synchronous active-high reset
i_z80_mreq_n  in  1  Z80 memory request, async, active low
i_z80_rd_n  in  1  Z80 read strobe, async, active low
i_z80_wr_n  in  1  Z80 write strobe, async, active low
i_z80_addr  in  ADDR_WIDTH  Z80 address bus
i_z80_data  in  DATA_WIDTH  Z80 data bus (write data)
o_z80_data  out  DATA_WIDTH  read data to Z80
o_z80_data_oe  out  1  enable for the o_z80_data bus driver
o_z80_wait_n  out  1  Z80 WAIT, active low
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
o_wb_we  out  1  1 = write
o_wb_addr  out  ADDR_WIDTH  Wishbone address
o_wb_data  out  DATA_WIDTH  Wishbone write data
i_wb_ack  in  1  Wishbone ack
i_wb_stall  in  1  Wishbone stall
i_wb_data  in  DATA_WIDTH  Wishbone read data
o_bus_error  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset values: cyc=0, stb=0, we=0, wb_addr=0, wb_data=0, o_z80_data=0, data_oe=0, wait_n=1, bus_error=0, state=IDLE, armed=0, timeout counter=0.
- Synchronisation:
  - mreq_n, rd_n and wr_n pass through 2-FF synchronisers that reset to 1.
  - addr and data are registered in a matching 2-stage pipe, so they align with the synced strobes.
- Request:
  - A request is synced mreq_n=0 with exactly one of rd_n/wr_n = 0.
  - Both rd_n and wr_n low is ignored; it is not an error.
- armed:
  - armed sets once synced mreq_n=1 is seen in IDLE.
  - A transaction starts only when armed=1, so a Z80 cycle already in progress at reset release is never issued.
- IDLE:
  - On a request with armed=1, go to REQ.
  - On that transition: latch we=!wr_n, wb_addr and wb_data from the aligned pipe; assert cyc=1, stb=1, wait_n=0; clear armed and the counter.
- REQ:
  - stb stays high while i_wb_stall=1.
  - On i_wb_stall=0: drop stb and go to ACK.
  - If i_wb_ack=1 in the same cycle, the transfer completes immediately, handled as in ACK.
- ACK:
  - On i_wb_ack=1: cyc=0 and wait_n=1, both registered, so one cycle after ack.
  - For a read, also latch o_z80_data=i_wb_data and set data_oe=1.
  - Then go to HOLD.
- HOLD:
  - Stay until synced mreq_n=1.
  - Then clear data_oe, set armed=1 and return to IDLE.
  - For writes data_oe stays 0 throughout.
- Timeout:
  - The counter increments every cycle in REQ and ACK.
  - On reaching TIMEOUT_CYCLES-1 without ack: cyc=0, stb=0, wait_n=1, bus_error pulses for 1 cycle.
  - A read additionally returns ERROR_DATA with data_oe=1. Then go to HOLD.
  - An ack arriving in the same cycle as the timeout takes priority; it is a normal completion with no error.
- Stray i_wb_ack while cyc=0 is ignored.
- Latency, zero-stall slave acking on the cycle after stb: 2 (sync) + 1 (issue) + 1 (ack) + 1 (release) = wait_n returns high 5 i_clk after MREQ_n falls.
- Clock requirement: i_clk ≥ 8× the Z80 clock, so WAIT is asserted before the Z80 samples it in T2.
- Reset mid-operation aborts with no ack wait: outputs return to reset values and armed=0 until MREQ_n is seen high.

Test Plan:
- Read, zero-stall slave acking 1 cycle after stb, i_wb_data=8'h3C, addr 16'h0123 → one stb with we=0, wb_addr=16'h0123; wait_n low then high 5 cycles after MREQ_n falls; o_z80_data=8'h3C with data_oe=1 until MREQ_n rises.
- Write of 8'hA5 to 16'h8000, slave stalls 3 cycles → stb high for exactly 4 cycles, we=1, wb_data=8'hA5; data_oe never asserted; exactly one stb accepted.
- Slave never acks → after 64 cycles: bus_error 1-cycle pulse, cyc=0, wait_n=1; o_z80_data=8'hFF with data_oe=1 for the read.
- Ack on the same cycle as the timeout → normal completion, bus_error stays 0, returned data = i_wb_data.
- i_reset pulsed during ACK with MREQ_n held low → cyc=0, wait_n=1 next cycle; no new stb until MREQ_n goes high then low again.
- rd_n and wr_n both low with MREQ_n low; also a stray i_wb_ack while idle → no Wishbone activity, wait_n stays 1.
